// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, using one full-subtractor cell and a registered borrow.
// Results are registered on entry to DONE and held until the next run completes.
module serial_subtractor #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] diff,
    output logic                borrow_out,
    output logic                overflow
);

    localparam int CW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NUM_BITS-1:0] a_q, a_d;
    logic [NUM_BITS-1:0] b_q, b_d;
    logic [NUM_BITS-1:0] res_q, res_d;
    logic [NUM_BITS-1:0] diff_q, diff_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bw_q, bw_d;
    logic                brw_q, brw_d;
    logic                ovf_q, ovf_d;

    logic accept;
    logic d_bit;
    logic bw_nxt;

    // Start is honoured only when no operation is in flight.
    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    assign d_bit  = a_q[0] ^ b_q[0] ^ bw_q;
    assign bw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bw_d    = bw_q;
        brw_d   = brw_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    bw_d    = 1'b0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[NUM_BITS-1:1]};
                bw_d  = bw_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // a_q[0]/b_q[0] hold the operand MSBs on the final bit.
                    diff_d  = {d_bit, res_q[NUM_BITS-1:1]};
                    brw_d   = bw_nxt;
                    ovf_d   = (a_q[0] != b_q[0]) && (d_bit != a_q[0]);
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bw_q    <= 1'b0;
            brw_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bw_q    <= bw_d;
            brw_q   <= brw_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = brw_q;
    assign overflow   = ovf_q;

`ifndef SYNTHESIS
    logic [NUM_BITS-1:0] chk_a_q, chk_b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_a_q <= '0;
            chk_b_q <= '0;
        end else if (accept) begin
            chk_a_q <= a;
            chk_b_q <= b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept)
            assert (!$isunknown({a, b}))
            else $error("serial_subtractor: unknown operand bits at start");
        if (!rst && (state_q == ST_DONE))
            assert (diff == NUM_BITS'(chk_a_q - chk_b_q))
            else $error("serial_subtractor: diff %h differs from a-b", diff);
    end
`endif

endmodule
